fft_sample_feeder: RTL and testbench
====================================

// Module: fft_sample_feeder
// PURPOSE
//  Producer side of the fft_controller sample interface. Buffers one frame of
//  ADC samples (2*FRAME_PAIRS bytes) and pulses fft_controller.start. After
//  sync_i_out rises, presents two samples per fft_clk period on
//  sampled_in_0/1. Sits between the ADC capture path and fft_controller.
//  Everything runs in the global_clk domain.
// PARAMETERS
//  DATA_W        8      sample width
//  FRAME_PAIRS   128    sample pairs per FFT frame (frame = 256 samples)
//  ADDR_W        8      log2(2*FRAME_PAIRS), buffer address width
//  START_LEN     50     fft_start pulse length in global_clk cycles (1000 ns @ 50 MHz)
//  SYNC_TIMEOUT  65535  cycles to wait for sync_i before re-pulsing start
// PORTS
//  global_clk    in   1       system clock; sole clock of the block
//  rst_n         in   1       asynchronous, active-low reset
//  adc_data      in   DATA_W  incoming ADC sample
//  adc_valid     in   1       adc_data valid this cycle
//  fft_clk       in   1       fft_controller sample clock (derived from global_clk)
//  sync_i        in   1       fft_controller sync_i_out; rising edge = input window opens
//  fft_start     out  1       start pulse to fft_controller
//  sampled_out_0 out  DATA_W  even sample of current pair -> sampled_in_0
//  sampled_out_1 out  DATA_W  odd sample of current pair  -> sampled_in_1
//  busy          out  1       high in every state except FILL
//  overrun       out  1       sticky: adc_valid arrived while not in FILL
// BEHAVIOUR
//  Reset: state=FILL, all counters 0, every output 0. Buffer contents don't care.
//  Asserting rst_n low mid-frame aborts the frame. No partial output is replayed.
//  FILL: each adc_valid writes adc_data to buf[wr_ptr] and increments wr_ptr.
//   On the write of address 2*FRAME_PAIRS-1, go to START. wr_ptr wraps to 0.
//  START: fft_start=1 for exactly START_LEN cycles, then go to WAIT_SYNC.
//  WAIT_SYNC: fft_start=0. Detect a sync_i rising edge (sync_i=1, sync_q=0),
//   then go to STREAM with rd_pair=0. If SYNC_TIMEOUT cycles pass with no edge,
//   go back to START.
//  STREAM: detect a fft_clk falling edge (fft_clk=0, fft_clk_q=1).
//   Each edge issues a read of pair rd_pair.
//   Two cycles after the detect cycle: sampled_out_0=buf[2*rd_pair],
//   sampled_out_1=buf[2*rd_pair+1]. The outputs hold until the next update.
//   The first pair is presented at the first fft_clk falling edge after sync_i rises.
//   After pair FRAME_PAIRS-1 has been presented, go to FILL and zero
//   sampled_out_0/1 on the next fft_clk falling edge.
//  sync_i edges outside WAIT_SYNC are ignored.
//  adc_valid outside FILL: sample dropped, overrun<=1 (cleared only by reset).
//  adc_valid on the final FILL write: accepted; the next cycle is START.
//  fft_clk period must be >= 4 global_clk cycles. Outputs are then stable
//   >= 1 cycle before the next fft_clk rising edge.
//  Sample order: arrival order. Sample 2k goes to _0, sample 2k+1 goes to _1.
//  Unsigned data; no arithmetic on samples.
// STRUCTURE
//  fft_pkg: DATA_W, FRAME_PAIRS, ADDR_W constants; feeder state encoding
//   (FILL, START, WAIT_SYNC, STREAM). Also shared with fft_controller benches.
//  Sub-module feeder_frame_ram: simple dual-port, 2*FRAME_PAIRS x DATA_W,
//   1 write port, synchronous read, maps to iCE40 EBR. Read as two sequential
//   accesses per pair, or two banks (even/odd) read in parallel; implementer's choice.
//  Top level: FSM, wr_ptr/rd_pair/timeout counters, edge detectors, output regs.
// TESTING
//  1 Reset: rst_n=0 with random inputs -> all outputs 0, busy=0.
//  2 Full frame: feed 256 samples 0..255 with adc_valid -> fft_start high
//    50 cycles. Then sync_i rise -> 128 pairs (0,1),(2,3)..(254,255), each
//    stable at fft_clk posedge; busy=0 after the last pair.
//  3 Overrun: 3 adc_valid pulses during STREAM -> overrun=1, streamed data unchanged.
//  4 Timeout: SYNC_TIMEOUT=100, never raise sync_i -> fft_start re-pulses
//    every 150 cycles.
//  5 Reset mid-STREAM after pair 40: rst_n low 3 cycles -> outputs 0,
//    state FILL; a new 256-sample frame then streams correctly from pair 0.
//  6 Spurious sync_i rise during FILL -> ignored; streaming starts only after
//    the sync_i edge that follows START.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Package : fft_pkg
// Frame geometry and feeder state encoding shared by the FFT sample path.
// Rev     : 1.0
// ============================================================================
package fft_pkg;

    localparam int DATA_W      = 8;
    localparam int FRAME_PAIRS = 128;
    localparam int ADDR_W      = 8;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        START     = 2'd1,
        WAIT_SYNC = 2'd2,
        STREAM    = 2'd3
    } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/feeder_frame_ram.sv
`default_nettype none
// ============================================================================
// Module : feeder_frame_ram
// One-frame sample store split into even/odd banks so a pair reads in one access.
// Rev    : 1.0
// ============================================================================
module feeder_frame_ram
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-2:0] rd_pair,
    output logic [DATA_W-1:0] rd_data_0,
    output logic [DATA_W-1:0] rd_data_1
);

    logic [DATA_W-1:0] even_mem [FRAME_PAIRS];
    logic [DATA_W-1:0] odd_mem  [FRAME_PAIRS];

    // No reset on storage or read registers so both banks map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !wr_addr[0]) begin
            even_mem[wr_addr[ADDR_W-1:1]] <= wr_data;
        end
        if (wr_en && wr_addr[0]) begin
            odd_mem[wr_addr[ADDR_W-1:1]] <= wr_data;
        end
        if (rd_en) begin
            rd_data_0 <= even_mem[rd_pair];
            rd_data_1 <= odd_mem[rd_pair];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module : fft_sample_feeder
// Buffers one ADC frame, pulses fft_start, then streams pairs on fft_clk falls.
// Rev    : 1.0
// ============================================================================
module fft_sample_feeder
    import fft_pkg::*;
#(
    parameter int START_LEN    = 50,
    parameter int SYNC_TIMEOUT = 65535
) (
    input  logic              global_clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              fft_clk,
    input  logic              sync_i,
    output logic              fft_start,
    output logic [DATA_W-1:0] sampled_out_0,
    output logic [DATA_W-1:0] sampled_out_1,
    output logic              busy,
    output logic              overrun
);

    localparam int CNT_W  = $clog2((SYNC_TIMEOUT > START_LEN) ? SYNC_TIMEOUT : START_LEN) + 1;
    localparam int PAIR_W = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(2 * FRAME_PAIRS - 1);
    localparam logic [PAIR_W-1:0] LAST_PAIR  = PAIR_W'(FRAME_PAIRS - 1);
    localparam logic [CNT_W-1:0]  START_LAST = CNT_W'(START_LEN - 1);
    localparam logic [CNT_W-1:0]  SYNC_LAST  = CNT_W'(SYNC_TIMEOUT - 1);

    feeder_state_e     state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PAIR_W-1:0] rd_pair_q, rd_pair_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic              last_rd_q, last_rd_d;
    logic              clear_pend_q, clear_pend_d;
    logic [DATA_W-1:0] out0_q, out0_d, out1_q, out1_d;
    logic              fft_start_q, fft_start_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              sync_q, fft_clk_q;

    logic              ram_we, ram_re;
    logic [DATA_W-1:0] ram_rd_0, ram_rd_1;
    logic              sync_rise, fclk_fall;

    assign sync_rise = sync_i & ~sync_q;
    assign fclk_fall = ~fft_clk & fft_clk_q;

    feeder_frame_ram u_ram (
        .clk       (global_clk),
        .wr_en     (ram_we),
        .wr_addr   (wr_ptr_q),
        .wr_data   (adc_data),
        .rd_en     (ram_re),
        .rd_pair   (rd_pair_q),
        .rd_data_0 (ram_rd_0),
        .rd_data_1 (ram_rd_1)
    );

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_pair_d    = rd_pair_q;
        cnt_d        = cnt_q;
        rd_valid_d   = 1'b0;
        last_rd_d    = last_rd_q;
        clear_pend_d = clear_pend_q;
        out0_d       = out0_q;
        out1_d       = out1_q;
        overrun_d    = overrun_q | (adc_valid && (state_q != FILL));
        ram_we       = 1'b0;
        ram_re       = 1'b0;

        // Read data lands one cycle after the issue; register it a cycle later.
        if (rd_valid_q) begin
            out0_d = ram_rd_0;
            out1_d = ram_rd_1;
        end
        if (fclk_fall && clear_pend_q) begin
            out0_d       = '0;
            out1_d       = '0;
            clear_pend_d = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (adc_valid) begin
                    ram_we = 1'b1;
                    if (wr_ptr_q == LAST_ADDR) begin
                        wr_ptr_d = '0;
                        cnt_d    = '0;
                        state_d  = START;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_SYNC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_SYNC: begin
                if (sync_rise) begin
                    cnt_d     = '0;
                    rd_pair_d = '0;
                    last_rd_d = 1'b0;
                    state_d   = STREAM;
                end else if (cnt_q == SYNC_LAST) begin
                    cnt_d   = '0;
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STREAM: begin
                if (fclk_fall && !last_rd_q) begin
                    ram_re     = 1'b1;
                    rd_valid_d = 1'b1;
                    last_rd_d  = (rd_pair_q == LAST_PAIR);
                    rd_pair_d  = rd_pair_q + 1'b1;
                end else if (rd_valid_q && last_rd_q) begin
                    // Final pair is being presented this edge; outputs clear on the next fall.
                    last_rd_d    = 1'b0;
                    clear_pend_d = 1'b1;
                    state_d      = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        fft_start_d = (state_d == START);
        busy_d      = (state_d != FILL);
    end

    always_ff @(posedge global_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            wr_ptr_q     <= '0;
            rd_pair_q    <= '0;
            cnt_q        <= '0;
            rd_valid_q   <= 1'b0;
            last_rd_q    <= 1'b0;
            clear_pend_q <= 1'b0;
            out0_q       <= '0;
            out1_q       <= '0;
            fft_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            sync_q       <= 1'b0;
            fft_clk_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_pair_q    <= rd_pair_d;
            cnt_q        <= cnt_d;
            rd_valid_q   <= rd_valid_d;
            last_rd_q    <= last_rd_d;
            clear_pend_q <= clear_pend_d;
            out0_q       <= out0_d;
            out1_q       <= out1_d;
            fft_start_q  <= fft_start_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            sync_q       <= sync_i;
            fft_clk_q    <= fft_clk;
        end
    end

    assign fft_start     = fft_start_q;
    assign sampled_out_0 = out0_q;
    assign sampled_out_1 = out1_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module : tb_fft_sample_feeder
// Directed frame scenarios for fft_sample_feeder with a sample-pattern model.
// Rev    : 1.0
// ============================================================================
module tb_fft_sample_feeder;
    import fft_pkg::*;

    localparam int START_LEN    = 50;
    localparam int SYNC_TIMEOUT = 100;
    localparam int FCLK_PERIOD  = 8;

    logic              global_clk = 1'b0;
    logic              rst_n      = 1'b1;
    logic [DATA_W-1:0] adc_data   = '0;
    logic              adc_valid  = 1'b0;
    logic              fft_clk    = 1'b0;
    logic              sync_i     = 1'b0;
    logic              fft_start;
    logic [DATA_W-1:0] sampled_out_0;
    logic [DATA_W-1:0] sampled_out_1;
    logic              busy;
    logic              overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] got [FRAME_PAIRS];

    typedef struct {
        int pat;
        bit spurious;
        bit ovr;
        bit timeout;
        int stop_after;
        bit exp_ovr;
    } scen_t;

    typedef struct {
        int          pat;
        int          k;
        logic [15:0] exp;
    } spot_t;

    scen_t scen  [4];
    spot_t spots [7];

    fft_sample_feeder #(
        .START_LEN    (START_LEN),
        .SYNC_TIMEOUT (SYNC_TIMEOUT)
    ) dut (
        .global_clk    (global_clk),
        .rst_n         (rst_n),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .fft_clk       (fft_clk),
        .sync_i        (sync_i),
        .fft_start     (fft_start),
        .sampled_out_0 (sampled_out_0),
        .sampled_out_1 (sampled_out_1),
        .busy          (busy),
        .overrun       (overrun)
    );

    // fft_clk toggles on global_clk falling edges, period of 8 global cycles.
    always #5 global_clk = ~global_clk;
    always #(FCLK_PERIOD * 5) fft_clk = ~fft_clk;

    function automatic logic [7:0] sample(input int pat, input int i);
        case (pat)
            0:       return 8'(i);
            1:       return 8'(255 - i);
            2:       return 8'((i * 37 + 5) & 255);
            default: return 8'(i ^ 8'hA5);
        endcase
    endfunction

    task automatic step();
        @(posedge global_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_fclk_rise(output bit ok);
        logic prev;
        ok = 1'b0;
        for (int i = 0; i < 2 * FCLK_PERIOD; i++) begin
            prev = fft_clk;
            step();
            if (!prev && fft_clk) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL fclk_rise_wait: got no fft_clk rise within %0d cycles", 2 * FCLK_PERIOD);
        end
    endtask

    task automatic feed_frame(input int pat, input bit spurious);
        for (int i = 0; i < 2 * FRAME_PAIRS; i++) begin
            adc_data  = sample(pat, i);
            adc_valid = 1'b1;
            sync_i    = spurious && (i >= 100) && (i < 110);
            step();
        end
        adc_valid = 1'b0;
        sync_i    = 1'b0;
    endtask

    task automatic measure(input bit level, output int n);
        n = 0;
        while ((fft_start == level) && (n < 1000)) begin
            n++;
            step();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, int'(fft_start), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
        check({tag, "_outs"}, int'({sampled_out_1, sampled_out_0}), 0);
    endtask

    task automatic stream_frame(input int pat, input bit ovr, input int stop_after);
        bit ok;
        wait_fclk_rise(ok);
        if (!ok) return;
        sync_i = 1'b1;
        for (int k = 0; k < FRAME_PAIRS; k++) begin
            wait_fclk_rise(ok);
            if (!ok) return;
            if (k == 2) sync_i = 1'b0;
            got[k] = {sampled_out_1, sampled_out_0};
            check($sformatf("pair%0d_pat%0d", k, pat), int'(got[k]),
                  int'({sample(pat, 2 * k + 1), sample(pat, 2 * k)}));
            if (ovr && (k >= 10) && (k < 13)) begin
                adc_data  = 8'hEE;
                adc_valid = 1'b1;
                step();
                adc_valid = 1'b0;
            end
            if (k == stop_after) return;
        end
        check("busy_after_last_pair", int'(busy), 0);
        wait_fclk_rise(ok);
        if (!ok) return;
        check("outs_zero_after_frame", int'({sampled_out_1, sampled_out_0}), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;

        scen[0] = '{pat: 0, spurious: 1'b0, ovr: 1'b0, timeout: 1'b0, stop_after: -1, exp_ovr: 1'b0};
        scen[1] = '{pat: 1, spurious: 1'b1, ovr: 1'b1, timeout: 1'b0, stop_after: -1, exp_ovr: 1'b1};
        scen[2] = '{pat: 2, spurious: 1'b0, ovr: 1'b0, timeout: 1'b1, stop_after: 40, exp_ovr: 1'b1};
        scen[3] = '{pat: 3, spurious: 1'b0, ovr: 1'b0, timeout: 1'b0, stop_after: -1, exp_ovr: 1'b0};

        spots[0] = '{pat: 0, k: 0,   exp: 16'h0100};
        spots[1] = '{pat: 0, k: 127, exp: 16'hFFFE};
        spots[2] = '{pat: 1, k: 0,   exp: 16'hFEFF};
        spots[3] = '{pat: 1, k: 40,  exp: 16'hAEAF};
        spots[4] = '{pat: 2, k: 40,  exp: 16'hBA95};
        spots[5] = '{pat: 3, k: 0,   exp: 16'hA4A5};
        spots[6] = '{pat: 3, k: 127, exp: 16'h5A5B};

        // Reset with random activity on every input.
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adc_data  = 8'($urandom);
            adc_valid = 1'($urandom);
            sync_i    = 1'($urandom);
            step();
            check_all_zero($sformatf("reset%0d", i));
        end
        adc_valid = 1'b0;
        sync_i    = 1'b0;
        rst_n     = 1'b1;
        step();

        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < FRAME_PAIRS; k++) got[k] = '0;

            feed_frame(scen[s].pat, scen[s].spurious);
            check("start_after_fill", int'(fft_start), 1);
            check("busy_after_fill", int'(busy), 1);
            measure(1'b1, n);
            check("start_len", n, START_LEN);

            if (scen[s].timeout) begin
                measure(1'b0, n);
                check("sync_timeout_gap", n, SYNC_TIMEOUT);
                measure(1'b1, n);
                check("start_repulse_len", n, START_LEN);
            end

            if (scen[s].spurious) begin
                for (int r = 0; r < 2; r++) begin
                    wait_fclk_rise(ok);
                    check("no_early_stream", int'({sampled_out_1, sampled_out_0}), 0);
                    check("busy_in_wait", int'(busy), 1);
                end
            end

            stream_frame(scen[s].pat, scen[s].ovr, scen[s].stop_after);
            check($sformatf("overrun_scen%0d", s), int'(overrun), int'(scen[s].exp_ovr));

            for (int j = 0; j < 7; j++) begin
                if (spots[j].pat == scen[s].pat) begin
                    check($sformatf("spot_pat%0d_k%0d", spots[j].pat, spots[j].k),
                          int'(got[spots[j].k]), int'(spots[j].exp));
                end
            end

            if (scen[s].stop_after >= 0) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("midstream_reset");
                step();
                step();
                step();
                rst_n = 1'b1;
                step();
                check_all_zero("after_reset_release");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
